// File: rtl/pad_bidir_ctrl.sv
// Core-side controller for a bank of bidirectional pads: glitch-safe turnaround,
// input sync, edge-pending flags. Optional input filter: PAD_BIDIR_CTRL_DEBOUNCE_EN.
module pad_lane
`ifdef PAD_BIDIR_CTRL_DEBOUNCE_EN
#(
  parameter int DEB_CYC = 4
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic pad_c,
  input  logic sup,
  input  logic clr,
  output logic din,
  output logic rise,
  output logic fall
);
  logic s1, s2, din_nxt;

`ifdef PAD_BIDIR_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYC);
  logic [DW-1:0] dcnt;
  logic din_q, hit;

  assign hit     = (s2 != din_q) && (dcnt == DW'(DEB_CYC-1));
  assign din_nxt = hit ? s2 : din_q;
  assign din     = din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt  <= '0;
      din_q <= 1'b0;
    end else begin
      din_q <= din_nxt;
      if (s2 == din_q || hit) dcnt <= '0;
      else                    dcnt <= dcnt + DW'(1);
    end
  end
`else
  assign din_nxt = s1;
  assign din     = s2;
`endif

  // set wins over a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= pad_c;
      s2   <= s1;
      rise <= (rise & ~clr) | (din_nxt & ~din & ~sup);
      fall <= (fall & ~clr) | (~din_nxt & din & ~sup);
    end
  end
endmodule

module pad_bidir_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 2,
  parameter int DEB_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] out_data,
  input  logic [WIDTH-1:0] out_en,
  input  logic [WIDTH-1:0] in_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] pend_clr,
  input  logic [WIDTH-1:0] pad_c,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_oen,
  output logic [WIDTH-1:0] pad_ie,
  output logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise_pend,
  output logic [WIDTH-1:0] fall_pend,
  output logic             irq,
  output logic             busy
);
  localparam int CW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, PREP, ENABLE, SETTLE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] chg, tgt;

  if (TURN_CYC < 1 || DEB_CYC < 2) begin : g_bad_param
    $error("pad_bidir_ctrl: TURN_CYC must be >= 1 and DEB_CYC >= 2");
  end

  // chg doubles as the edge-suppress mask; it is cleared on return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      chg     <= '0;
      tgt     <= '0;
      busy    <= 1'b0;
      pad_i   <= '0;
      pad_oen <= '1;
      pad_ie  <= '0;
    end else begin
      pad_ie <= in_en;
      case (state)
        IDLE: begin
          pad_i <= out_data;
          if (out_en != ~pad_oen) begin
            chg   <= out_en ^ ~pad_oen;
            tgt   <= out_en;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          pad_i   <= out_data;
          pad_oen <= pad_oen | (chg & ~tgt);
          state   <= ENABLE;
        end
        ENABLE: begin
          pad_oen <= pad_oen & ~(chg & tgt);
          cnt     <= '0;
          state   <= SETTLE;
        end
        SETTLE: begin
          if (cnt == CW'(TURN_CYC-1)) begin
            cnt   <= '0;
            chg   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    pad_lane
`ifdef PAD_BIDIR_CTRL_DEBOUNCE_EN
      #(.DEB_CYC(DEB_CYC))
`endif
      u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .pad_c(pad_c[g]),
        .sup  (chg[g]),
        .clr  (pend_clr[g]),
        .din  (din[g]),
        .rise (rise_pend[g]),
        .fall (fall_pend[g])
      );
  end

  assign irq = |((rise_pend | fall_pend) & irq_mask);
endmodule

// File: doc/pad_bidir_ctrl.md
Name: pad_bidir_ctrl

Overview:
- Core-side controller for a bank of bidirectional pad cells; sits between the risc8 GPIO register file and the pad ring.
- Drives each pad's data-out (I), active-low output enable (OEN) and input enable (IE); samples each pad's receive output (C).
- Provides glitch-safe direction turnaround, input synchronisation, and rise/fall edge-pending flags with a masked interrupt.

Parameters:
- WIDTH, 8, number of pads in the bank.
- TURN_CYC, 2, settle cycles after any direction change; edge detection is masked on changed bits during this window; minimum 1.
- DEB_CYC, 4, stable-sample count for the debounce filter; used only with DEBOUNCE_EN; minimum 2.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- out_data  input  WIDTH  value to drive on pads.
- out_en  input  WIDTH  direction request; 1 = drive pad.
- in_en  input  WIDTH  receiver enable request.
- irq_mask  input  WIDTH  1 = bit's pending edge contributes to irq.
- pend_clr  input  WIDTH  single-cycle write-1-to-clear of pending flags.
- pad_c  input  WIDTH  receive value from pad cells.
- pad_i  output  WIDTH  data to pad cells.
- pad_oen  output  WIDTH  output enable to pad cells, active low.
- pad_ie  output  WIDTH  input enable to pad cells.
- din  output  WIDTH  synchronised (optionally filtered) pad value.
- rise_pend  output  WIDTH  rising edge seen since last clear.
- fall_pend  output  WIDTH  falling edge seen since last clear.
- irq  output  1  OR over (rise_pend|fall_pend) & irq_mask.
- busy  output  1  direction sequence in progress.

Behaviour:
- Reset values: pad_oen all 1 (all pads input); pad_i 0; pad_ie 0; din 0; both sync stages 0; rise_pend/fall_pend 0; busy 0; FSM in IDLE; settle counter 0; mask vector 0.
- pad_ie: registered copy of in_en, 1-cycle latency, independent of the FSM.
- pad_i in IDLE: registered copy of out_data, 1-cycle latency.
- FSM states: IDLE, PREP, ENABLE, SETTLE.
- IDLE -> PREP when out_en != ~pad_oen. Capture chg = out_en ^ ~pad_oen and tgt = out_en.
- PREP (1 cycle): pad_i <= out_data. Bits with chg & ~tgt set pad_oen to 1, so drivers are released first.
- ENABLE (1 cycle): bits with chg & tgt clear pad_oen to 0, so data is set up one cycle before enable.
- SETTLE: counts TURN_CYC cycles, then returns to IDLE.
- busy = 1 in PREP, ENABLE and SETTLE.
- out_en changes while busy are ignored until IDLE, then re-evaluated; no request is lost because IDLE compares levels.
- out_data changes while busy update pad_i only in PREP and in IDLE.
- Input path: 2-flop synchroniser on pad_c; din = stage2. A pad_c change is visible on din after the 2nd clk edge.
- Edge detect: on any edge where next din differs from current din, set rise_pend (0->1) or fall_pend (1->0) in that same cycle.
- Edge detect is suppressed for bits in chg from PREP through the end of SETTLE; din itself still updates.
- Pending flags are sticky. pend_clr clears them. If set and clear hit the same cycle, set wins.
- irq is combinational from registered flags and irq_mask.
- Async reset mid-sequence: immediately returns all outputs to reset values, including pad_oen = 1.

Optional Feature:
- Macro: PAD_BIDIR_CTRL_DEBOUNCE_EN.
- Defined: a per-bit counter follows stage2. din updates only after stage2 differs from din for DEB_CYC consecutive cycles; the counter resets whenever stage2 equals din. Edge flags derive from the filtered din; latency becomes 2+DEB_CYC cycles.
- Undefined: no filter; din = stage2; no counter logic is synthesised.

Test Plan:
- Reset: hold rst_n=0, toggle all inputs -> pad_oen=8'hFF, pad_i=0, pad_ie=0, din=0, irq=0, busy=0.
- Input->output on bit 3: out_data=8'h08, out_en 0->8'h08 -> busy=1; pad_i=8'h08 one cycle before pad_oen=8'hF7; busy low after 2+TURN_CYC=4 cycles.
- Output->input: from out_en=8'h08, set out_en=0 -> pad_oen[3]=1 at PREP; a pad_c[3] toggle during SETTLE sets no pending flag; a toggle after SETTLE sets the flag.
- Edges: in_en=8'hFF, pad_c[0] 0->1 -> din[0]=1 and rise_pend[0]=1 two edges later; irq=1 only with irq_mask[0]=1; pend_clr=1 -> flag 0. Pulse pend_clr coincident with a new edge -> flag stays 1.
- Mid-sequence request and reset: change out_en during SETTLE -> a new sequence starts right after IDLE. Assert rst_n=0 in ENABLE -> pad_oen=8'hFF immediately.
- With PAD_BIDIR_CTRL_DEBOUNCE_EN: a 3-cycle pad_c glitch produces no din change; a pulse stable 4+ cycles updates din at 2+4 cycles.
